// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM state enum, default timeout and one-hot to index helper
package sram_arbiter_pkg;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester bus (i_req/i_rnw/i_addr/i_wdata -> o_gnt/o_done/o_err/o_rdata) plus SRAM controller side (o_mem_* -> i_mem_*); slave = arbiter view, master = environment view
interface sram_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] i_rnw;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] i_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_wdata;
  logic [NUM_REQ-1:0] o_gnt;
  logic [NUM_REQ-1:0] o_done;
  logic o_err;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic o_mem_en;
  logic o_mem_rnw;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic i_mem_data_valid;
  modport slave (
    input i_req, i_rnw, i_addr, i_wdata, i_mem_rdata, i_mem_data_valid,
    output o_gnt, o_done, o_err, o_rdata, o_mem_en, o_mem_rnw, o_mem_addr, o_mem_wdata
  );
  modport master (
    output i_req, i_rnw, i_addr, i_wdata, i_mem_rdata, i_mem_data_valid,
    input o_gnt, o_done, o_err, o_rdata, o_mem_en, o_mem_rnw, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/sram_arbiter_rr.sv
// rr_arbiter: combinational rotating-priority picker; req (N) + ptr (highest-priority index) -> one-hot gnt (N)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);
  logic [N-1:0] rot;
  logic [N-1:0] pick;
  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  assign rot = N'({req, req} >> ptr);
  assign pick = rot & (~rot + N'(1));
  assign gnt = N'({pick, pick} >> (N - int'(ptr)));
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter of NUM_REQ requesters onto one SRAM controller; clk, n_rst (sync active-low), bus (sram_arbiter_if.slave)
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic n_rst,
  sram_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] w;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [CW-1:0] cnt;
  logic err_q;
  logic rnw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  rr_arbiter #(.N(NUM_REQ)) u_rr (.req(bus.i_req), .ptr(ptr), .gnt(gnt));
  assign w = IW'(oh_idx(4'(gnt)));
  assign bus.o_gnt = (n_rst && state == IDLE) ? gnt : '0;
  assign bus.o_mem_en = n_rst && state == ISSUE;
  assign bus.o_mem_rnw = rnw_q;
  assign bus.o_mem_addr = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_done = done_q;
  assign bus.o_err = err_q;
  assign bus.o_rdata = rdata_q;
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      rnw_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= '0;
      err_q <= 1'b0;
      case (state)
        IDLE:
          if (|bus.i_req) begin
            state <= ISSUE;
            gnt_q <= gnt;
            rnw_q <= bus.i_rnw[w];
            addr_q <= bus.i_addr[w];
            wdata_q <= bus.i_wdata[w];
            ptr <= (w == IW'(NUM_REQ - 1)) ? '0 : w + IW'(1);
          end
        ISSUE: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT:
          if (bus.i_mem_data_valid) begin
            state <= IDLE;
            done_q <= gnt_q;
            if (rnw_q) rdata_q <= bus.i_mem_rdata;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= IDLE;
            done_q <= gnt_q;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a one-cycle SRAM responder model
module tb_sram_arbiter;
  typedef struct {int idx; int gap;} gnt_t;
  typedef struct {logic rnw; logic [31:0] addr; logic [31:0] wdata;} mem_t;
  typedef struct {int idx; logic err; logic [31:0] rdata; int lat;} done_t;
  logic clk = 1'b0;
  logic n_rst;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int last_gnt = 0;
  int gnt_seen = 0;
  bit mem_respond = 1'b1;
  logic [31:0] mem_data = '0;
  gnt_t exp_gnt[$];
  mem_t exp_mem[$];
  done_t exp_done[$];
  sram_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  sram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic expire(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask
  initial begin
    logic en;
    bus.i_mem_data_valid = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      en = bus.o_mem_en;
      @(posedge clk);
      #1;
      bus.i_mem_data_valid = en && mem_respond;
      bus.i_mem_rdata = en ? mem_data : '0;
    end
  end
  initial begin
    done_t d;
    mem_t m;
    gnt_t g;
    forever begin
      @(negedge clk);
      if (|bus.o_done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 64'(bus.o_done), 0);
        else begin
          d = exp_done.pop_front();
          chk("done_vec", 64'(bus.o_done), 64'(1 << d.idx));
          chk("done_err", 64'(bus.o_err), 64'(d.err));
          chk("rdata", 64'(bus.o_rdata), 64'(d.rdata));
          chk("done_lat", 64'(cyc - last_gnt), 64'(d.lat));
        end
      end
      if (bus.o_mem_en) begin
        if (exp_mem.size() == 0) chk("unexpected_mem_en", 64'(bus.o_mem_en), 0);
        else begin
          m = exp_mem.pop_front();
          chk("mem_rnw", 64'(bus.o_mem_rnw), 64'(m.rnw));
          chk("mem_addr", 64'(bus.o_mem_addr), 64'(m.addr));
          chk("mem_wdata", 64'(bus.o_mem_wdata), 64'(m.wdata));
          chk("mem_lat", 64'(cyc - last_gnt), 1);
        end
      end
      if (|bus.o_gnt) begin
        if (exp_gnt.size() == 0) chk("unexpected_gnt", 64'(bus.o_gnt), 0);
        else begin
          g = exp_gnt.pop_front();
          chk("gnt_vec", 64'(bus.o_gnt), 64'(1 << g.idx));
          if (g.gap >= 0) chk("gnt_gap", 64'(cyc - last_gnt), 64'(g.gap));
        end
        last_gnt = cyc;
        gnt_seen++;
      end
    end
  end
  task automatic req_one(input int k, input logic rnw, input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 1'b0;
    bus.i_rnw[k] = rnw;
    bus.i_addr[k] = addr;
    bus.i_wdata[k] = wdata;
    bus.i_req[k] = 1'b1;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = bus.o_gnt[k];
    end
    if (!got) expire("grant_wait");
    @(posedge clk);
    #1;
    bus.i_req[k] = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && exp_done.size() != 0; n++) @(posedge clk);
    if (exp_done.size() != 0) begin
      expire("done_wait");
      exp_done.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int base;
    bit got;
    n_rst = 1'b0;
    bus.i_req = '0;
    bus.i_rnw = '1;
    bus.i_addr = '0;
    bus.i_wdata = '0;
    repeat (3) @(posedge clk);
    bus.i_req = 2'b11;
    @(negedge clk);
    chk("rst_gnt", 64'(bus.o_gnt), 0);
    chk("rst_mem_en", 64'(bus.o_mem_en), 0);
    chk("rst_done", 64'(bus.o_done), 0);
    chk("rst_err", 64'(bus.o_err), 0);
    chk("rst_rdata", 64'(bus.o_rdata), 0);
    @(posedge clk);
    #1;
    bus.i_req = '0;
    n_rst = 1'b1;
    // single write from requester 0
    exp_gnt.push_back('{0, -1});
    exp_mem.push_back('{1'b0, 32'h80000010, 32'hDEADBEEF});
    exp_done.push_back('{0, 1'b0, 32'h0, 3});
    req_one(0, 1'b0, 32'h80000010, 32'hDEADBEEF);
    wait_done(20);
    // read from requester 1
    mem_data = 32'h12345678;
    exp_gnt.push_back('{1, -1});
    exp_mem.push_back('{1'b1, 32'h80000020, 32'h0});
    exp_done.push_back('{1, 1'b0, 32'h12345678, 3});
    req_one(1, 1'b1, 32'h80000020, 32'h0);
    wait_done(20);
    // write leaves o_rdata untouched
    mem_data = 32'hFFFF0000;
    exp_gnt.push_back('{0, -1});
    exp_mem.push_back('{1'b0, 32'h00000040, 32'hA5A5A5A5});
    exp_done.push_back('{0, 1'b0, 32'h12345678, 3});
    req_one(0, 1'b0, 32'h00000040, 32'hA5A5A5A5);
    wait_done(20);
    // timeout: no data_valid, 15 WAIT cycles then done+err
    mem_respond = 1'b0;
    exp_gnt.push_back('{1, -1});
    exp_mem.push_back('{1'b1, 32'h80000030, 32'h0});
    exp_done.push_back('{1, 1'b1, 32'h12345678, 17});
    req_one(1, 1'b1, 32'h80000030, 32'h0);
    wait_done(40);
    mem_respond = 1'b1;
    exp_gnt.push_back('{0, -1});
    exp_mem.push_back('{1'b0, 32'h00000044, 32'h11112222});
    exp_done.push_back('{0, 1'b0, 32'h12345678, 3});
    req_one(0, 1'b0, 32'h00000044, 32'h11112222);
    wait_done(20);
    // fairness from reset with both requesting continuously
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    mem_data = 32'hCAFEF00D;
    bus.i_rnw = 2'b11;
    bus.i_addr[0] = 32'h00000100;
    bus.i_addr[1] = 32'h00000200;
    bus.i_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back('{i % 2, (i == 0) ? -1 : 3});
      exp_mem.push_back('{1'b1, (i % 2 == 0) ? 32'h00000100 : 32'h00000200, 32'h0});
      exp_done.push_back('{i % 2, 1'b0, 32'hCAFEF00D, 3});
    end
    base = gnt_seen;
    bus.i_req = 2'b11;
    for (int n = 0; n < 30 && gnt_seen < base + 4; n++) @(posedge clk);
    if (gnt_seen < base + 4) expire("fair_grants");
    #1;
    bus.i_req = '0;
    wait_done(20);
    // reset during WAIT abandons the access
    mem_respond = 1'b0;
    exp_gnt.push_back('{0, -1});
    exp_mem.push_back('{1'b0, 32'h00000300, 32'h55AA55AA});
    req_one(0, 1'b0, 32'h00000300, 32'h55AA55AA);
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b0;
    bus.i_rnw[1] = 1'b1;
    bus.i_addr[1] = 32'h00000400;
    bus.i_req = 2'b11;
    @(negedge clk);
    chk("rst_hold_gnt", 64'(bus.o_gnt), 0);
    chk("rst_hold_mem_en", 64'(bus.o_mem_en), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    mem_respond = 1'b1;
    chk("post_rst_rdata", 64'(bus.o_rdata), 0);
    chk("post_rst_done", 64'(bus.o_done), 0);
    exp_gnt.push_back('{0, -1});
    exp_mem.push_back('{1'b0, 32'h00000300, 32'h55AA55AA});
    exp_done.push_back('{0, 1'b0, 32'h0, 3});
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = |bus.o_gnt;
    end
    if (!got) expire("post_rst_grant");
    @(posedge clk);
    #1;
    bus.i_req = '0;
    wait_done(20);
    repeat (5) @(posedge clk);
    chk("gnt_queue_left", 64'(exp_gnt.size()), 0);
    chk("mem_queue_left", 64'(exp_mem.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation bound expired");
    $fatal(1);
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum cycles in WAIT before the access is aborted.
REQ-005 SHALL have ports clk (in, 1, clock) and n_rst (in, 1, reset); one clock; reset is synchronous and active-low.
REQ-006 SHALL have port i_req (in, NUM_REQ, per-requester access request, held until granted).
REQ-007 SHALL have ports i_rnw (in, NUM_REQ, 1=read), i_addr (in, NUM_REQ x ADDR_WIDTH, word-aligned byte address) and i_wdata (in, NUM_REQ x DATA_WIDTH, write data).
REQ-008 SHALL have port o_gnt (out, NUM_REQ, one-hot grant pulse).
REQ-009 SHALL have ports o_done (out, NUM_REQ, one-hot completion pulse) and o_err (out, 1, timeout flag, valid with o_done).
REQ-010 SHALL have port o_rdata (out, DATA_WIDTH, read data of the last completed access, shared).
REQ-011 SHALL have ports o_mem_en, o_mem_rnw (out, 1), o_mem_addr (out, ADDR_WIDTH) and o_mem_wdata (out, DATA_WIDTH), driving the SRAM controller slave side.
REQ-012 SHALL have ports i_mem_rdata (in, DATA_WIDTH) and i_mem_data_valid (in, 1), the controller response.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT; transitions: IDLE->ISSUE on any i_req; ISSUE->WAIT always; WAIT->IDLE on i_mem_data_valid or on timeout.
REQ-014 SHALL, in IDLE with any i_req high, combinationally assert o_gnt for exactly one winner, chosen round-robin, and capture that requester's i_rnw/i_addr/i_wdata and index at the clock edge.
REQ-015 SHALL give highest priority after a grant to requester (winner+1) mod NUM_REQ; the priority pointer updates only on grant.
REQ-016 SHALL assert o_gnt only in IDLE; o_gnt is all-zero in ISSUE and WAIT, even if requests are pending.
REQ-017 SHALL, in ISSUE, drive o_mem_en=1 for exactly one cycle with the captured rnw/addr/wdata; o_mem_en=0 in all other states.
REQ-018 SHALL hold o_mem_rnw/o_mem_addr/o_mem_wdata at the captured values in ISSUE and WAIT.
REQ-019 SHALL, in WAIT with i_mem_data_valid=1, register i_mem_rdata into o_rdata when the access is a read, and pulse o_done[winner] for one cycle on the following cycle with o_err=0.
REQ-020 SHALL leave o_rdata unchanged by write completions and by timeouts.
REQ-021 SHALL count WAIT cycles with a counter cleared on entry to WAIT; reaching TIMEOUT cycles without i_mem_data_valid aborts to IDLE and pulses o_done[winner] and o_err for one cycle on the following cycle.
REQ-022 SHALL ignore i_mem_data_valid outside WAIT.
REQ-023 SHALL permit a new grant in the same cycle o_done pulses (the IDLE cycle), giving 3-cycle back-to-back throughput.
REQ-024 SHALL ignore requesters whose i_req drops before grant; no o_done is produced for them.

Reset
REQ-025 SHALL, on n_rst=0 at a clock edge: state=IDLE, priority pointer=requester 0, WAIT counter=0, o_done=0, o_err=0, o_rdata=0, captured rnw=1, address=0, write data=0.
REQ-026 SHALL abandon any in-flight access on reset without an o_done pulse; o_mem_en=0 and o_gnt=0 while n_rst=0.

Structure
REQ-027 SHALL place the state enum (IDLE/ISSUE/WAIT) and the default TIMEOUT constant in shared package sram_arbiter_pkg.
REQ-028 SHALL instantiate one sub-module, rr_arbiter (combinational rotating-priority one-hot picker: inputs request vector and priority pointer, output one-hot grant).

Verification
REQ-029 SHALL cover single write: i_req[0]=1, addr=0x80000010, wdata=0xDEADBEEF at cycle 0 -> o_gnt[0] at cycle 0, o_mem_en with those values at cycle 1, data_valid at cycle 2, o_done[0]=1 and o_err=0 at cycle 3.
REQ-030 SHALL cover read: i_req[1] read, addr=0x80000020, model returns 0x12345678 -> o_rdata=0x12345678 with o_done[1] three cycles after grant.
REQ-031 SHALL cover fairness: i_req=2'b11 held continuously from reset -> grants alternate 0,1,0,1 at 3-cycle spacing.
REQ-032 SHALL cover timeout: model never asserts data_valid -> o_done and o_err pulse after TIMEOUT=15 WAIT cycles, o_rdata unchanged, next grant possible.
REQ-033 SHALL cover reset mid-operation: n_rst=0 during WAIT -> no o_done; after reset, o_rdata=0, and the first grant goes to requester 0 when both request.
